// File: rtl/banco_operandos.sv
// Operand register bank for the calculator: shifts hex digits into A and B,
// latches the operation and produces a registered result and display value.
module banco_operandos #(
  parameter  int DIGITS = 4,
  parameter  int CNT_W  = 3,
  localparam int W      = 4 * DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_1,
  input  logic             trigger_2,
  input  logic             trigger_op,
  input  logic             reset_a_reg,
  input  logic [2:0]       estado,
  input  logic [3:0]       digit_in,
  input  logic [1:0]       op_in,
  output logic [W-1:0]     display_value,
  output logic             result_valid,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [1:0]       r_op;
  logic [W-1:0]     r_result;
  logic [CNT_W-1:0] r_count_a;
  logic [CNT_W-1:0] r_count_b;
  logic             r_result_valid;
  logic             r_carry;
  logic             r_neg;
  logic [W-1:0]     r_display;

  logic             w_clear;
  logic             w_calc;
  logic             w_load_any;
  logic             w_a_ge_b;
  logic [W:0]       w_sum;
  logic [W-1:0]     w_diff;
  logic [W-1:0]     w_and;
  logic [W-1:0]     w_or;
  logic [W-1:0]     w_res;
  logic             w_carry;
  logic             w_neg;
  logic [W-1:0]     w_disp;

  assign w_clear    = rst | reset_a_reg;
  assign w_calc     = (r_state == S_CALC);
  assign w_load_any = trigger_1 | trigger_2;

  // pending is the CALC state; a trigger_op seen in CALC keeps it there
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_IDLE;
    if (trigger_op) w_state_next = S_CALC;
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bitwise
      assign w_and[gi] = r_a[gi] & r_b[gi];
      assign w_or[gi]  = r_a[gi] | r_b[gi];
    end
  endgenerate

  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_a_ge_b = (r_a >= r_b);
  assign w_diff   = w_a_ge_b ? (r_a - r_b) : (r_b - r_a);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_neg   = 1'b0;
    case (r_op)
      2'b00: begin w_res = w_sum[W-1:0]; w_carry = w_sum[W]; end
      2'b01: begin w_res = w_diff; w_neg = ~w_a_ge_b; end
      2'b10: w_res = w_and;
      default: w_res = w_or;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_count_a <= '0;
      r_count_b <= '0;
    end else begin
      if (trigger_1 && (r_count_a < CNT_W'(DIGITS))) begin
        r_a       <= {r_a[W-5:0], digit_in};
        r_count_a <= r_count_a + 1'b1;
      end
      if (trigger_2 && (r_count_b < CNT_W'(DIGITS))) begin
        r_b       <= {r_b[W-5:0], digit_in};
        r_count_b <= r_count_b + 1'b1;
      end
      if (trigger_op) r_op <= op_in;
    end
  end

  // A new digit invalidates the result even if a computation finishes this cycle
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_carry        <= 1'b0;
      r_neg          <= 1'b0;
    end else if (w_load_any) begin
      r_result_valid <= 1'b0;
      r_carry        <= 1'b0;
      r_neg          <= 1'b0;
    end else if (w_calc) begin
      r_result       <= w_res;
      r_result_valid <= 1'b1;
      r_carry        <= w_carry;
      r_neg          <= w_neg;
    end
  end

  always_comb begin
    w_disp = '0;
    case (estado)
      3'd0: w_disp = r_a;
      3'd1: w_disp = r_b;
      3'd2: w_disp = {{(W-2){1'b0}}, r_op};
      3'd3: w_disp = r_result_valid ? r_result : '0;
      default: w_disp = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) r_display <= '0;
    else         r_display <= w_disp;
  end

  assign display_value = r_display;
  assign result_valid  = r_result_valid;
  assign carry_flag    = r_carry;
  assign neg_flag      = r_neg;
  assign count_a       = r_count_a;
  assign count_b       = r_count_b;

endmodule

// File: tb/tb_banco_operandos.sv
// Directed bench for banco_operandos with hand-computed expected values.
module tb_banco_operandos;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trigger_1 = 1'b0;
  logic        trigger_2 = 1'b0;
  logic        trigger_op = 1'b0;
  logic        reset_a_reg = 1'b0;
  logic [2:0]  estado = 3'd0;
  logic [3:0]  digit_in = 4'd0;
  logic [1:0]  op_in = 2'd0;
  logic [15:0] display_value;
  logic        result_valid;
  logic        carry_flag;
  logic        neg_flag;
  logic [2:0]  count_a;
  logic [2:0]  count_b;

  int n_checks = 0;
  int n_errors = 0;

  banco_operandos #(.DIGITS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .trigger_1(trigger_1), .trigger_2(trigger_2),
    .trigger_op(trigger_op), .reset_a_reg(reset_a_reg), .estado(estado),
    .digit_in(digit_in), .op_in(op_in), .display_value(display_value),
    .result_valid(result_valid), .carry_flag(carry_flag), .neg_flag(neg_flag),
    .count_a(count_a), .count_b(count_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input bit to_b, input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      digit_in = v[4*i +: 4];
      if (to_b) trigger_2 = 1'b1;
      else      trigger_1 = 1'b1;
      tick();
      trigger_1 = 1'b0;
      trigger_2 = 1'b0;
    end
  endtask

  // Pulse trigger_op and wait until the result and display have settled
  task automatic run_op(input logic [1:0] op);
    op_in      = op;
    trigger_op = 1'b1;
    tick();
    trigger_op = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    do_reset();
    tick();
    chk("rst_display", display_value, 16'h0000);
    chk("rst_count_a", count_a, 3'd0);
    chk("rst_count_b", count_b, 3'd0);
    chk("rst_valid", result_valid, 1'b0);

    // Load A with 1,2,3,4 then try a fifth digit
    estado = 3'd0;
    load(1'b0, 16'h1234);
    tick();
    chk("load_a_display", display_value, 16'h1234);
    chk("load_a_count", count_a, 3'd4);
    digit_in = 4'h5; trigger_1 = 1'b1;
    tick();
    trigger_1 = 1'b0;
    tick();
    chk("sat_a_display", display_value, 16'h1234);
    chk("sat_a_count", count_a, 3'd4);

    // Add with carry, including the two-cycle latency of result_valid
    do_reset();
    load(1'b0, 16'hFFFF);
    load(1'b1, 16'h0001);
    estado = 3'd3;
    op_in = 2'b00; trigger_op = 1'b1;
    tick();
    trigger_op = 1'b0;
    chk("add_valid_pending", result_valid, 1'b0);
    tick();
    chk("add_valid_rise", result_valid, 1'b1);
    chk("add_carry", carry_flag, 1'b1);
    tick();
    chk("add_display", display_value, 16'h0000);
    estado = 3'd1;
    tick();
    chk("add_show_b", display_value, 16'h0001);

    // Subtraction, both signs
    do_reset();
    load(1'b0, 16'h0010);
    load(1'b1, 16'h0025);
    estado = 3'd3;
    run_op(2'b01);
    chk("sub_neg_display", display_value, 16'h0015);
    chk("sub_neg_flag", neg_flag, 1'b1);
    chk("sub_neg_carry", carry_flag, 1'b0);
    do_reset();
    load(1'b0, 16'h0025);
    load(1'b1, 16'h0010);
    run_op(2'b01);
    chk("sub_pos_display", display_value, 16'h0015);
    chk("sub_pos_flag", neg_flag, 1'b0);

    // Bitwise operations
    do_reset();
    load(1'b0, 16'hF0F0);
    load(1'b1, 16'h0FF0);
    run_op(2'b10);
    chk("and_display", display_value, 16'h00F0);
    run_op(2'b11);
    chk("or_display", display_value, 16'hFFF0);
    chk("or_flags", {carry_flag, neg_flag}, 2'b00);
    estado = 3'd2;
    tick();
    chk("op_display", display_value, 16'h0003);
    estado = 3'd5;
    tick();
    chk("blank_display", display_value, 16'h0000);

    // A digit after a valid result hides it; B is saturated so stays put
    estado = 3'd3;
    digit_in = 4'h1; trigger_2 = 1'b1;
    tick();
    trigger_2 = 1'b0;
    chk("stale_valid", result_valid, 1'b0);
    tick();
    chk("stale_display", display_value, 16'h0000);
    estado = 3'd1;
    tick();
    chk("stale_b_kept", display_value, 16'h0FF0);

    // reset_a_reg wins over trigger_1 in the same cycle
    estado = 3'd0;
    reset_a_reg = 1'b1; trigger_1 = 1'b1; digit_in = 4'h9;
    tick();
    reset_a_reg = 1'b0; trigger_1 = 1'b0;
    chk("prio_count_a", count_a, 3'd0);
    tick();
    chk("prio_display", display_value, 16'h0000);

    // Simultaneous loads into A and B
    digit_in = 4'h7; trigger_1 = 1'b1; trigger_2 = 1'b1;
    tick();
    trigger_1 = 1'b0; trigger_2 = 1'b0;
    chk("sim_count_a", count_a, 3'd1);
    chk("sim_count_b", count_b, 3'd1);
    tick();
    chk("sim_a", display_value, 16'h0007);
    estado = 3'd1;
    tick();
    chk("sim_b", display_value, 16'h0007);

    // Back-to-back trigger_op: add (0x000E) then or (0x0007)
    estado = 3'd3;
    op_in = 2'b00; trigger_op = 1'b1;
    tick();
    op_in = 2'b11;
    tick();
    trigger_op = 1'b0;
    chk("retrig_first_valid", result_valid, 1'b1);
    tick();
    tick();
    chk("retrig_display", display_value, 16'h0007);
    chk("retrig_carry", carry_flag, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
